reservation_station_multi_cdb: RTL

Next-generation reservation station for the out-of-order execution units. It holds up to RS_DEPTH decoded instructions and snoops CDB_PORTS result buses per cycle to capture pending operands. It dispatches the oldest ready entry first, rather than the lowest index. It adds three things: same-cycle capture of results for instructions being accepted, a flush input for mispredict/exception recovery, and occupancy reporting to the dispatcher.

---
 rtl/reservation_station_multi_cdb_pkg.sv | 26 ++
 rtl/reservation_station_multi_cdb_rs_age_select.sv | 29 ++
 rtl/reservation_station_multi_cdb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_multi_cdb_pkg.sv
// Shared types for the reservation station: decoded add/sub control and the
// result-broadcast bus record.
package reservation_station_multi_cdb_pkg;

  localparam int TAG_W = 5;
  localparam int XLEN  = 32;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_ADDU = 2'd2,
    ALU_SUBU = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [4:0] rd;
  } add_sub_decode_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rs_id;
    logic [XLEN-1:0]  value;
  } cdb_t;

endpackage

// File: rtl/reservation_station_multi_cdb_rs_age_select.sv
// Picks the ready entry with the smallest age (oldest instruction).
module rs_age_select
  import reservation_station_multi_cdb_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int AGE_W    = 3
) (
  input  logic [RS_DEPTH-1:0]            ready,
  input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
  output logic                           found,
  output logic [AGE_W-1:0]               index
);

  logic [AGE_W-1:0] best;

  always_comb begin
    found = 1'b0;
    index = '0;
    best  = '1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i] && (!found || age[i] < best)) begin
        found = 1'b1;
        best  = age[i];
        index = AGE_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station_multi_cdb.sv
// Reservation station snooping several result buses, dispatching oldest-ready
// first, with same-cycle take bypass, flush and occupancy reporting.
module reservation_station_multi_cdb
  import reservation_station_multi_cdb_pkg::*;
#(
  parameter int  OPERANDS     = 2,
  parameter int  RS_OFFSET    = 0,
  parameter int  RS_DEPTH     = 8,
  parameter int  RS_ID_WIDTH  = 5,
  parameter int  CDB_PORTS    = 2,
  parameter type CONTROL_TYPE = add_sub_decode_t
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    take_valid,
  output logic                                    take_ready,
  input  logic [OPERANDS-1:0]                     op_value_valid_in,
  input  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]    op_rs_id_in,
  input  logic [OPERANDS-1:0][31:0]               op_value_in,
  input  CONTROL_TYPE                             control_in,
  output logic [RS_ID_WIDTH-1:0]                  id_taken,
  input  logic [CDB_PORTS-1:0]                    cdb_valid,
  input  logic [CDB_PORTS-1:0][RS_ID_WIDTH-1:0]   cdb_rs_id,
  input  logic [CDB_PORTS-1:0][31:0]              cdb_value,
  output logic                                    output_valid,
  input  logic                                    output_ready,
  output logic [OPERANDS-1:0][31:0]               op_value_out,
  output CONTROL_TYPE                             control_out,
  output logic [RS_ID_WIDTH-1:0]                  dispatch_id,
  output logic [$clog2(RS_DEPTH+1)-1:0]           occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0]                                valid_q;
  CONTROL_TYPE                                        ctrl_q [RS_DEPTH];
  logic [RS_DEPTH-1:0][OPERANDS-1:0]                  opv_q;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][RS_ID_WIDTH-1:0] tag_q;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][31:0]            val_q;
  logic [RS_DEPTH-1:0][IDX_W-1:0]                     age_q;

  cdb_t [CDB_PORTS-1:0]                    cdb;
  logic [RS_DEPTH-1:0][OPERANDS-1:0]       snoop_hit;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][31:0] snoop_val;
  logic [OPERANDS-1:0]                     take_hit;
  logic [OPERANDS-1:0][31:0]               take_hit_val;
  logic [OPERANDS-1:0]                     take_opv;
  logic [OPERANDS-1:0][31:0]               take_val;

  logic [OCC_W-1:0]    occ;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [RS_DEPTH-1:0] ready;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    sel_age;
  logic [IDX_W-1:0]    new_age;
  logic                take_fire;
  logic                disp_fire;
  logic                age_ok;
  int                  age_cnt;

  // Lowest-numbered matching port wins, so scan from the top down.
  function automatic logic [32:0] cdb_lookup(input cdb_t [CDB_PORTS-1:0] bus,
                                             input logic [RS_ID_WIDTH-1:0] tag);
    logic [32:0] r;
    r = '0;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (bus[p].valid && bus[p].rs_id == TAG_W'(tag)) r = {1'b1, bus[p].value};
    end
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb[p].valid = cdb_valid[p];
      cdb[p].rs_id = TAG_W'(cdb_rs_id[p]);
      cdb[p].value = cdb_value[p];
    end
  end

  always_comb begin
    snoop_hit = '0;
    snoop_val = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int o = 0; o < OPERANDS; o++) begin
        {snoop_hit[i][o], snoop_val[i][o]} = cdb_lookup(cdb, tag_q[i][o]);
      end
    end
  end

  always_comb begin
    take_hit     = '0;
    take_hit_val = '0;
    take_opv     = '0;
    take_val     = '0;
    for (int o = 0; o < OPERANDS; o++) begin
      {take_hit[o], take_hit_val[o]} = cdb_lookup(cdb, op_rs_id_in[o]);
      take_opv[o] = op_value_valid_in[o] | take_hit[o];
      take_val[o] = op_value_valid_in[o] ? op_value_in[o] : take_hit_val[o];
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < RS_DEPTH; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) ready[i] = valid_q[i] & (&opv_q[i]);
  end

  rs_age_select #(
    .RS_DEPTH (RS_DEPTH),
    .AGE_W    (IDX_W)
  ) u_age_select (
    .ready (ready),
    .age   (age_q),
    .found (sel_found),
    .index (sel_idx)
  );

  assign sel_age   = age_q[sel_idx];
  assign take_ready = free_found & ~flush;
  assign take_fire  = take_valid & take_ready;
  assign disp_fire  = sel_found & output_ready;
  // A take can only fire when a slot is free, so occ < RS_DEPTH and this fits.
  assign new_age    = IDX_W'(occ - OCC_W'(disp_fire));

  assign id_taken     = RS_ID_WIDTH'(free_idx) + RS_ID_WIDTH'(RS_OFFSET);
  assign output_valid = sel_found;
  assign op_value_out = val_q[sel_idx];
  assign control_out  = ctrl_q[sel_idx];
  assign dispatch_id  = RS_ID_WIDTH'(sel_idx) + RS_ID_WIDTH'(RS_OFFSET);
  assign occupancy    = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      opv_q   <= '0;
      tag_q   <= '0;
      val_q   <= '0;
      age_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ctrl_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      age_q   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        for (int o = 0; o < OPERANDS; o++) begin
          if (valid_q[i] && !opv_q[i][o] && snoop_hit[i][o]) begin
            opv_q[i][o] <= 1'b1;
            val_q[i][o] <= snoop_val[i][o];
          end
        end
        if (disp_fire && valid_q[i] && age_q[i] > sel_age) age_q[i] <= age_q[i] - 1'b1;
      end
      if (disp_fire) valid_q[sel_idx] <= 1'b0;
      // The take slot is invalid, so it never collides with snoop or dispatch.
      if (take_fire) begin
        valid_q[free_idx] <= 1'b1;
        ctrl_q[free_idx]  <= control_in;
        opv_q[free_idx]   <= take_opv;
        tag_q[free_idx]   <= op_rs_id_in;
        val_q[free_idx]   <= take_val;
        age_q[free_idx]   <= new_age;
      end
    end
  end

  // Ages of valid entries must be exactly 0..occ-1, each once.
  always_comb begin
    age_ok  = 1'b1;
    age_cnt = 0;
    for (int a = 0; a < RS_DEPTH; a++) begin
      age_cnt = 0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && int'(age_q[i]) == a) age_cnt = age_cnt + 1;
      end
      if (a < int'(occ)) age_ok = age_ok & (age_cnt == 1);
      else               age_ok = age_ok & (age_cnt == 0);
    end
  end

  ages_permutation: assert property (@(posedge clk) disable iff (rst) age_ok);

endmodule
